// File: rtl/systolic_feeder.sv
// Operand feeder for a 2x2 output-stationary systolic array: buffers one k_len-beat job,
// then replays it with the row/column skew the array expects, followed by a zero drain.
module systolic_feeder #(
   parameter int unsigned datawith  = 16,
   parameter int unsigned k_len     = 2,
   parameter int unsigned drain_cyc = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*datawith-1:0] in_a,
   input  logic [2*datawith-1:0] in_b,
   output logic [datawith-1:0]   data_1,
   output logic [datawith-1:0]   data_2,
   output logic [datawith-1:0]   weight_1,
   output logic [datawith-1:0]   weight_2,
   output logic                  systolic_en,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned cnt_w   = $clog2(k_len + 1);
   localparam int unsigned drain_w = $clog2(drain_cyc + 1);

   localparam logic [cnt_w-1:0]   last_beat  = cnt_w'(k_len - 1);
   localparam logic [cnt_w-1:0]   last_step  = cnt_w'(k_len);
   localparam logic [drain_w-1:0] last_drain = drain_w'(drain_cyc - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StStream, StDrain, StDone} state_e;

   state_e               state_q, state_d;
   logic [cnt_w-1:0]     beat_q, beat_d;
   logic [cnt_w-1:0]     step_q, step_d;
   logic [drain_w-1:0]   drain_q, drain_d;
   logic                 xfer;

   // a0/a1 hold rows A[0][k]/A[1][k]; b0/b1 hold columns B[k][0]/B[k][1].
   logic [datawith-1:0]  a0_q [k_len];
   logic [datawith-1:0]  a1_q [k_len];
   logic [datawith-1:0]  b0_q [k_len];
   logic [datawith-1:0]  b1_q [k_len];
   logic [datawith-1:0]  a0_v [k_len];
   logic [datawith-1:0]  a1_v [k_len];
   logic [datawith-1:0]  b0_v [k_len];
   logic [datawith-1:0]  b1_v [k_len];

   logic [datawith-1:0]  d1_d, d2_d, w1_d, w2_d;

   assign xfer = in_valid & in_ready & ~clear;

   // Buffer contents including the beat accepted on this edge, so step 0 can launch
   // straight from the last load transfer (needed when k_len=1).
   always_comb begin
      a0_v = a0_q;
      a1_v = a1_q;
      b0_v = b0_q;
      b1_v = b1_q;
      for (int i = 0; i < int'(k_len); i++) begin
         if (xfer && (beat_q == cnt_w'(i))) begin
            a0_v[i] = in_a[datawith-1:0];
            a1_v[i] = in_a[2*datawith-1:datawith];
            b0_v[i] = in_b[datawith-1:0];
            b1_v[i] = in_b[2*datawith-1:datawith];
         end
      end
   end

   // No reset: every job rewrites all beats before any of them is read.
   always_ff @(posedge clk) begin
      a0_q <= a0_v;
      a1_q <= a1_v;
      b0_q <= b0_v;
      b1_q <= b1_v;
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      step_d  = '0;
      drain_d = '0;
      unique case (state_q)
         StIdle: begin
            beat_d = '0;
            if (xfer) begin
               if (k_len == 1) begin
                  state_d = StStream;
               end else begin
                  state_d = StLoad;
                  beat_d  = cnt_w'(1);
               end
            end
         end
         StLoad: begin
            if (xfer) begin
               if (beat_q == last_beat) begin
                  state_d = StStream;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + cnt_w'(1);
               end
            end
         end
         StStream: begin
            if (step_q == last_step) begin
               state_d = StDrain;
            end else begin
               step_d = step_q + cnt_w'(1);
            end
         end
         StDrain: begin
            if (drain_q == last_drain) begin
               state_d = StDone;
            end else begin
               drain_d = drain_q + drain_w'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (clear) begin
         state_d = StIdle;
         beat_d  = '0;
         step_d  = '0;
         drain_d = '0;
      end
   end

   // Row 1 and column 1 lag row 0 / column 0 by one step to form the systolic skew.
   always_comb begin
      d1_d = '0;
      d2_d = '0;
      w1_d = '0;
      w2_d = '0;
      if (state_d == StStream) begin
         for (int i = 0; i < int'(k_len); i++) begin
            if (step_d == cnt_w'(i)) begin
               d1_d = a0_v[i];
               w1_d = b0_v[i];
            end
            if (step_d == cnt_w'(i + 1)) begin
               d2_d = a1_v[i];
               w2_d = b1_v[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         beat_q      <= '0;
         step_q      <= '0;
         drain_q     <= '0;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         systolic_en <= 1'b0;
         data_1      <= '0;
         data_2      <= '0;
         weight_1    <= '0;
         weight_2    <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         step_q      <= step_d;
         drain_q     <= drain_d;
         in_ready    <= (state_d == StIdle) || (state_d == StLoad);
         busy        <= (state_d != StIdle);
         done        <= (state_d == StDone);
         systolic_en <= (state_d == StStream) || (state_d == StDrain);
         data_1      <= d1_d;
         data_2      <= d2_d;
         weight_1    <= w1_d;
         weight_2    <= w2_d;
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed + randomized bench for systolic_feeder: a k_len=2 and a k_len=1 instance are
// checked cycle by cycle against a matrix-level model, with a behavioural 2x2 array attached.
`timescale 1ns/1ps
module tb_systolic_feeder;

   localparam int W  = 16;
   localparam int K0 = 2;
   localparam int D0 = 4;
   localparam int K1 = 1;
   localparam int D1 = 3;

   typedef struct packed {
      logic         rdy;
      logic         en;
      logic         busy;
      logic         done;
      logic [W-1:0] d1;
      logic [W-1:0] d2;
      logic [W-1:0] w1;
      logic [W-1:0] w2;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;

   logic           in_valid = 1'b0;
   logic [2*W-1:0] in_a = '0;
   logic [2*W-1:0] in_b = '0;
   logic           in_ready, systolic_en, busy, done;
   logic [W-1:0]   data_1, data_2, weight_1, weight_2;

   logic           s_in_valid = 1'b0;
   logic [2*W-1:0] s_in_a = '0;
   logic [2*W-1:0] s_in_b = '0;
   logic           s_in_ready, s_systolic_en, s_busy, s_done;
   logic [W-1:0]   s_data_1, s_data_2, s_weight_1, s_weight_2;

   int vectors = 0;
   int miscompares = 0;

   // Job matrices: A[0][k]=a0[k], A[1][k]=a1[k], B[k][0]=b0[k], B[k][1]=b1[k].
   logic [W-1:0] a0[2], a1[2], b0[2], b1[2];

   // Behavioural output-stationary array: acc index = 2*row + col.
   longint       acc[4];
   logic [W-1:0] h00, v00, h10, v01;

   always #5 clk = ~clk;

   systolic_feeder #(.datawith(W), .k_len(K0), .drain_cyc(D0)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .data_1(data_1), .data_2(data_2), .weight_1(weight_1), .weight_2(weight_2),
      .systolic_en(systolic_en), .busy(busy), .done(done)
   );

   systolic_feeder #(.datawith(W), .k_len(K1), .drain_cyc(D1)) dut1 (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
      .data_1(s_data_1), .data_2(s_data_2), .weight_1(s_weight_1), .weight_2(s_weight_2),
      .systolic_en(s_systolic_en), .busy(s_busy), .done(s_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic v, input logic [2*W-1:0] a,
                        input logic [2*W-1:0] b);
      if (sel) begin
         s_in_valid = v;
         s_in_a     = a;
         s_in_b     = b;
      end else begin
         in_valid = v;
         in_a     = a;
         in_b     = b;
      end
   endtask

   function automatic obs_t obs(input bit sel);
      if (sel) return {s_in_ready, s_systolic_en, s_busy, s_done,
                       s_data_1, s_data_2, s_weight_1, s_weight_2};
      return {in_ready, systolic_en, busy, done, data_1, data_2, weight_1, weight_2};
   endfunction

   function automatic obs_t mk(input logic rdy, input logic en, input logic bsy,
                               input logic dn);
      obs_t e;
      e      = '0;
      e.rdy  = rdy;
      e.en   = en;
      e.busy = bsy;
      e.done = dn;
      return e;
   endfunction

   // Skewed operands for stream step s of a K-beat job.
   function automatic obs_t exp_step(input int k, input int s);
      obs_t e;
      e = mk(1'b0, 1'b1, 1'b1, 1'b0);
      if (s < k) begin
         e.d1 = a0[s];
         e.w1 = b0[s];
      end
      if (s >= 1) begin
         e.d2 = a1[s-1];
         e.w2 = b1[s-1];
      end
      return e;
   endfunction

   task automatic check(input string tag, input bit sel, input obs_t e);
      obs_t o;
      o = obs(sel);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed rdy/en/busy/done=%b%b%b%b ops=%h,%h,%h,%h required rdy/en/busy/done=%b%b%b%b ops=%h,%h,%h,%h",
                tag, o.rdy, o.en, o.busy, o.done, o.d1, o.d2, o.w1, o.w2,
                e.rdy, e.en, e.busy, e.done, e.d1, e.d2, e.w1, e.w2);
      end
   endtask

   task automatic check_val(input string tag, input longint o, input longint e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %0d required %0d", tag, o, e);
      end
   endtask

   task automatic pe_reset();
      for (int i = 0; i < 4; i++) acc[i] = 0;
      h00 = '0;
      v00 = '0;
      h10 = '0;
      v01 = '0;
   endtask

   task automatic pe_cycle(input bit sel);
      obs_t o;
      o = obs(sel);
      if (o.en) begin
         acc[0] += longint'(o.d1) * longint'(o.w1);
         acc[1] += longint'(h00) * longint'(o.w2);
         acc[2] += longint'(o.d2) * longint'(v00);
         acc[3] += longint'(h10) * longint'(v01);
         h00 = o.d1;
         v00 = o.w1;
         h10 = o.d2;
         v01 = o.w2;
      end
   endtask

   // abort: 0 = none, 1 = clear on stream step 1, 2 = async reset in drain cycle 1.
   task automatic run_job(input bit sel, input bit rnd, input int gap, input bit hold,
                          input int abort);
      int k;
      int d;
      longint c;
      k = sel ? K1 : K0;
      d = sel ? D1 : D0;
      if (rnd) begin
         for (int i = 0; i < k; i++) begin
            a0[i] = W'($urandom);
            a1[i] = W'($urandom);
            b0[i] = W'($urandom);
            b1[i] = W'($urandom);
         end
      end
      pe_reset();
      check("pre_idle", sel, mk(1'b1, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < k; i++) begin
         drive(sel, 1'b1, {a1[i], a0[i]}, {b1[i], b0[i]});
         tick();
         if (i < k - 1) begin
            check("load", sel, mk(1'b1, 1'b0, 1'b1, 1'b0));
            for (int g = 0; g < gap; g++) begin
               drive(sel, 1'b0, 32'($urandom), 32'($urandom));
               tick();
               check("load_gap", sel, mk(1'b1, 1'b0, 1'b1, 1'b0));
            end
         end
      end
      drive(sel, hold, 32'($urandom), 32'($urandom));
      for (int s = 0; s <= k; s++) begin
         if (s > 0) begin
            if (hold) drive(sel, 1'b1, 32'($urandom), 32'($urandom));
            tick();
         end
         check("stream", sel, exp_step(k, s));
         pe_cycle(sel);
         if (abort == 1 && s == 1) begin
            clear = 1'b1;
            drive(sel, 1'b0, '0, '0);
            tick();
            clear = 1'b0;
            check("clear_idle", sel, mk(1'b1, 1'b0, 1'b0, 1'b0));
            for (int j = 0; j < k + d + 2; j++) begin
               tick();
               check("after_clear", sel, mk(1'b1, 1'b0, 1'b0, 1'b0));
            end
            return;
         end
      end
      for (int j = 0; j < d; j++) begin
         if (hold) drive(sel, 1'b1, 32'($urandom), 32'($urandom));
         tick();
         check("drain", sel, mk(1'b0, 1'b1, 1'b1, 1'b0));
         pe_cycle(sel);
         if (abort == 2 && j == 1) begin
            drive(sel, 1'b0, '0, '0);
            #3 rst = 1'b1;
            #1 check("rst_async", sel, mk(1'b0, 1'b0, 1'b0, 1'b0));
            tick();
            check("rst_held", sel, mk(1'b0, 1'b0, 1'b0, 1'b0));
            #2 rst = 1'b0;
            tick();
            check("rst_release", sel, mk(1'b1, 1'b0, 1'b0, 1'b0));
            return;
         end
      end
      if (hold) drive(sel, 1'b1, 32'($urandom), 32'($urandom));
      tick();
      check("done", sel, mk(1'b0, 1'b0, 1'b1, 1'b1));
      tick();
      check("post_idle", sel, mk(1'b1, 1'b0, 1'b0, 1'b0));
      for (int r = 0; r < 2; r++) begin
         for (int col = 0; col < 2; col++) begin
            c = 0;
            for (int i = 0; i < k; i++) begin
               c += longint'(r == 0 ? a0[i] : a1[i]) * longint'(col == 0 ? b0[i] : b1[i]);
            end
            check_val($sformatf("array_c%0d%0d", r, col), acc[2*r+col], c);
         end
      end
   endtask

   task automatic set_nominal();
      a0[0] = 16'd1; a0[1] = 16'd2;
      a1[0] = 16'd3; a1[1] = 16'd4;
      b0[0] = 16'd5; b0[1] = 16'd7;
      b1[0] = 16'd6; b1[1] = 16'd8;
   endtask

   initial begin
      tick();
      check("reset_k2", 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0));
      check("reset_k1", 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0));
      #2 rst = 1'b0;
      tick();
      check("first_ready_k2", 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0));
      check("first_ready_k1", 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0));

      // Nominal job; the array results must come out 19, 22, 43, 50.
      set_nominal();
      run_job(1'b0, 1'b0, 0, 1'b0, 0);
      check_val("nominal_c00", acc[0], 19);
      check_val("nominal_c11", acc[3], 50);

      // Back-pressure gap between the two beats.
      set_nominal();
      run_job(1'b0, 1'b0, 3, 1'b0, 0);

      // in_valid held high through stream/drain/done, then an immediate next job.
      run_job(1'b0, 1'b1, 0, 1'b1, 0);
      run_job(1'b0, 1'b1, 1, 1'b0, 0);

      // clear on step 1, then a clean job.
      run_job(1'b0, 1'b1, 0, 1'b0, 1);
      set_nominal();
      run_job(1'b0, 1'b0, 0, 1'b0, 0);

      // clear in IDLE discards the beat offered on the same edge.
      drive(1'b0, 1'b1, 32'($urandom), 32'($urandom));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      drive(1'b0, 1'b0, '0, '0);
      check("clear_discard", 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0));
      tick();
      check("clear_discard_hold", 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0));

      // Async reset mid-drain, then the nominal job again.
      run_job(1'b0, 1'b1, 0, 1'b0, 2);
      set_nominal();
      run_job(1'b0, 1'b0, 0, 1'b0, 0);

      // k_len=1 instance: directed single beat, then random jobs.
      a0[0] = 16'd3; a1[0] = 16'd9; b0[0] = 16'd2; b1[0] = 16'd4;
      run_job(1'b1, 1'b0, 0, 1'b0, 0);
      for (int j = 0; j < 3; j++) run_job(1'b1, 1'b1, 0, 1'b0, 0);

      for (int j = 0; j < 6; j++) run_job(1'b0, 1'b1, int'($urandom_range(0, 3)), 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter datawith, default 16, meaning element width in bits.
REQ-002 SHALL have parameter k_len, default 2, range 1..16, meaning inner (reduction) dimension in beats.
REQ-003 SHALL have parameter drain_cyc, default 4, range 1..15, meaning cycles of zero input after streaming, with systolic_en held high.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port clear, input, 1, synchronous abort to IDLE.
REQ-007 SHALL have port in_valid, input, 1, load beat valid.
REQ-008 SHALL have port in_ready, output, 1, load beat accept.
REQ-009 SHALL have port in_a, input, 2*datawith, [datawith-1:0]=A[0][k], upper half=A[1][k].
REQ-010 SHALL have port in_b, input, 2*datawith, [datawith-1:0]=B[k][0], upper half=B[k][1].
REQ-011 SHALL have ports data_1, data_2, weight_1, weight_2, output, datawith each, skewed operands to the 2x2 array.
REQ-012 SHALL have port systolic_en, output, 1, array enable.
REQ-013 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement the states IDLE, LOAD, STREAM, DRAIN and DONE; all outputs SHALL be registered.
REQ-016 in_ready SHALL be 1 in IDLE and LOAD and 0 otherwise; a beat transfers when in_valid and in_ready are both 1 at a clock edge.
REQ-017 Beat k (k = 0..k_len-1, counted from the first transfer) SHALL be stored into buffers A[.][k] and B[k][.].
REQ-018 State transitions:
- IDLE -> LOAD on the first transfer.
- LOAD -> STREAM on the edge accepting beat k_len-1; if k_len=1, IDLE -> STREAM directly.
- A gap with in_valid=0 SHALL hold LOAD with no timeout.
REQ-019 STREAM SHALL last k_len+1 cycles, step s = 0..k_len. Output values for step s:
- data_1 = A[0][s] if s<k_len, else 0.
- data_2 = A[1][s-1] if s>=1, else 0.
- weight_1 = B[s][0] if s<k_len, else 0.
- weight_2 = B[s-1][1] if s>=1, else 0.
REQ-020 The step-0 values and systolic_en=1 SHALL appear on the first cycle after the last load transfer; there SHALL be no bubble between load and stream.
REQ-021 DRAIN SHALL follow STREAM for exactly drain_cyc cycles, with all four operands 0 and systolic_en=1.
REQ-022 DONE SHALL last one cycle with done=1, systolic_en=0 and operands 0, then go to IDLE.
REQ-023 Outside STREAM and DRAIN, systolic_en SHALL be 0 and all operands SHALL be 0.
REQ-024 The block SHALL perform no arithmetic on operands; values pass bit-exact, and the step and beat counters SHALL NOT wrap within a job.
REQ-025 clear=1 at an edge SHALL force IDLE and set every output 0 except in_ready=1; any transfer on that same edge SHALL be discarded. clear SHALL take priority over all transitions.
REQ-026 Buffer contents SHALL be unaffected by clear or reset; a new job always overwrites all k_len beats before they are read.

Reset
REQ-027 While rst=1, the state SHALL be IDLE and data_1, data_2, weight_1, weight_2, systolic_en, busy and done SHALL be 0. in_ready SHALL be 0 during reset and 1 from the first edge after release.
REQ-028 Assertion of rst mid-job SHALL abort immediately without waiting for a clock; after release the block SHALL accept a fresh job from beat 0.

Verification
REQ-029 Nominal run, k_len=2, drain_cyc=4; beats in_a={3,1}, in_b={6,5} then in_a={4,2}, in_b={8,7}, i.e. A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> the stream steps SHALL read (d1,d2,w1,w2) = (1,0,5,0), (2,3,7,6), (0,4,0,8). After that: 4 zero cycles with systolic_en=1, then done=1 for one cycle. With the array attached, its results SHALL be 19, 22, 43, 50.
REQ-030 Back-pressure, same job with in_valid deasserted for 3 cycles between the two beats -> the outputs SHALL be identical to REQ-029, shifted 3 cycles; in_ready SHALL stay 1 throughout load.
REQ-031 Handshake blocking, in_valid held 1 with new data throughout the job -> in_ready=0 from STREAM through DONE, no beat consumed; the next job SHALL start on the edge after DONE.
REQ-032 clear asserted on step s=1 -> the next cycle SHALL show IDLE, systolic_en=0, operands 0, done never pulses; a following job SHALL complete correctly.
REQ-033 rst pulsed asynchronously mid-DRAIN -> the outputs SHALL go 0 without a clock edge; a post-reset job with k_len=2 SHALL match REQ-029.
REQ-034 k_len=1 build, single beat in_a={9,3}, in_b={4,2} -> steps (3,0,2,0), (0,9,0,4), then drain, then done.
